// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit sitting in EX, fed from the ID/EX register.
// Latency: 33 cycles start-to-done for normal ops (32 radix-2 steps), 1 cycle for divide special cases.
// Backpressure: stall_req freezes ID/EX and upstream until the done cycle; flush aborts with no done.
// Ports: clk/rst (async active-low); start, op (funct3), src1, src2, flush in;
//        stall_req, busy, done (1-cycle pulse), result (registered, held until next done) out.
module ex_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic             flush,
  output logic             stall_req,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t               state, state_nxt;
  logic [CW-1:0]        cnt;
  logic [2*WIDTH-1:0]   acc;    // mul: {product hi, multiplier/product lo}; div: {remainder, dividend/quotient}
  logic [WIDTH-1:0]     opnd;   // |multiplicand| or |divisor|
  logic [2:0]           op_q;
  logic                 neg1, neg2;

  // Operand decode, used only when accepting a new op in IDLE.
  logic             sgn1_in, sgn2_in, neg1_in, neg2_in;
  logic [WIDTH-1:0] abs1, abs2;
  logic             div_zero, div_ovf, special;
  logic [WIDTH-1:0] special_res;

  assign sgn1_in  = op[2] ? ~op[0] : (op[1:0] != 2'b11);   // MULHSU keeps src1 signed
  assign sgn2_in  = op[2] ? ~op[0] : ~op[1];
  assign neg1_in  = sgn1_in & src1[WIDTH-1];
  assign neg2_in  = sgn2_in & src2[WIDTH-1];
  assign abs1     = neg1_in ? -src1 : src1;
  assign abs2     = neg2_in ? -src2 : src2;

  assign div_zero = op[2] & (src2 == '0);
  assign div_ovf  = op[2] & ~op[0] & (src1 == {1'b1, {(WIDTH-1){1'b0}}}) & (&src2);
  assign special  = div_zero | div_ovf;
  // Divide by zero: quotient all ones, remainder = dividend. Overflow: quotient = dividend (0x8000_0000), remainder 0.
  assign special_res = div_zero ? (op[1] ? src1 : '1) : (op[1] ? '0 : src1);

  // One radix-2 step.
  logic [WIDTH:0]       mul_sum;
  logic [WIDTH:0]       part;
  logic                 div_ge;
  logic [WIDTH-1:0]     div_diff;
  logic [2*WIDTH-1:0]   mul_next, div_next, acc_step, prod;
  logic [WIDTH-1:0]     quo, rem, res_sel;

  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
  assign mul_next = {mul_sum, acc[WIDTH-1:1]};

  // Shifted remainder needs one extra bit before the trial subtract; a successful
  // difference is always below the divisor, so the low WIDTH bits are exact.
  assign part     = acc[2*WIDTH-1:WIDTH-1];
  assign div_ge   = part >= {1'b0, opnd};
  assign div_diff = part[WIDTH-1:0] - opnd;
  assign div_next = div_ge ? {div_diff, acc[WIDTH-2:0], 1'b1}
                           : {part[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};

  assign acc_step = op_q[2] ? div_next : mul_next;

  // Sign correction on the final step's value so result registers on the CALC->DONE edge.
  assign prod = (neg1 ^ neg2) ? -acc_step : acc_step;
  assign quo  = (neg1 ^ neg2) ? -acc_step[WIDTH-1:0] : acc_step[WIDTH-1:0];
  assign rem  = neg1 ? -acc_step[2*WIDTH-1:WIDTH] : acc_step[2*WIDTH-1:WIDTH];

  always_comb begin
    res_sel = prod[WIDTH-1:0];
    case (op_q)
      3'b000:                 res_sel = prod[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: res_sel = prod[2*WIDTH-1:WIDTH];
      3'b100, 3'b101:         res_sel = quo;
      default:                res_sel = rem;
    endcase
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state_nxt = special ? DONE : CALC;
        CALC:    if (cnt == LAST) state_nxt = DONE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      op_q   <= '0;
      neg1   <= 1'b0;
      neg2   <= 1'b0;
      result <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cnt  <= '0;
            op_q <= op;
            neg1 <= neg1_in;
            neg2 <= neg2_in;
            acc  <= op[2] ? {{WIDTH{1'b0}}, abs1} : {{WIDTH{1'b0}}, abs2};
            opnd <= op[2] ? abs2 : abs1;
            if (special) result <= special_res;
          end
        end
        CALC: begin
          acc <= acc_step;
          cnt <= cnt + CW'(1);
          if (cnt == LAST) result <= res_sel;
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign done      = (state == DONE) & ~flush;
  assign stall_req = start & ~done & ~flush;

endmodule

// File: tb/tb_ex_muldiv.sv
// Bench for ex_muldiv: directed and random ops; expected results and done cycles
// go into queues at issue and a monitor checks them whenever done pulses.
module tb_ex_muldiv;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] src1, src2;
  logic        flush;
  logic        stall_req, busy, done;
  logic [31:0] result;

  ex_muldiv #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .src1(src1), .src2(src2),
    .flush(flush), .stall_req(stall_req), .busy(busy), .done(done), .result(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int compared = 0;
  int mismatched = 0;
  int last_done = -10;
  logic [31:0] exp_res_q[$];
  int          exp_cyc_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model straight from the RV32M definitions.
  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    model = '0;
    case (o)
      3'd0: begin p = {32'b0, a} * {32'b0, b}; model = p[31:0]; end
      3'd1: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; model = p[63:32]; end
      3'd2: begin p = {{32{a[31]}}, a} * {32'b0, b}; model = p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; model = p[63:32]; end
      3'd4: if (b == 0) model = 32'hFFFF_FFFF;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) model = a;
            else model = sa / sb;
      3'd5: model = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: if (b == 0) model = a;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) model = 0;
            else model = sa % sb;
      default: model = (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    return (o >= 3'd4 && b == 0) ||
           ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (rst && done) begin
        if (exp_res_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_done: result %h with nothing outstanding (cycle %0d)", result, cyc);
        end else begin
          chk("done_result", result, exp_res_q.pop_front());
          chk("done_cycle", cyc, exp_cyc_q.pop_front());
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge of the done cycle with start still high.
  task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] e);
    int acc_cyc;
    bit chained;
    bit stall_bad;
    int n;
    chained = (cyc == last_done);
    op = o; src1 = a; src2 = b; start = 1'b1;
    acc_cyc = chained ? cyc + 1 : cyc;
    exp_res_q.push_back(e);
    exp_cyc_q.push_back(acc_cyc + (is_special(o, a, b) ? 1 : 33));
    #1;
    chk("stall_at_issue", {31'b0, stall_req}, chained ? 32'd0 : 32'd1);
    stall_bad = 0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (!done && stall_req !== 1'b1) stall_bad = 1;
    end while (!done && n < 200);
    chk("done_seen", {31'b0, done}, 32'd1);
    chk("stall_clear_on_done", {31'b0, stall_req}, 32'd0);
    chk("stall_held", {31'b0, stall_bad}, 32'd0);
    last_done = cyc;
  endtask

  task automatic idle(input int n);
    start = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h1;
      4: return $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  typedef struct {
    logic [2:0]  o;
    logic [31:0] a, b, e;
  } vec_t;

  vec_t dir[] = '{
    '{3'd0, 32'd7,          32'd6,          32'd42},
    '{3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0000},
    '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE},
    '{3'd2, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFF},
    '{3'd4, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD},
    '{3'd6, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF},
    '{3'd5, 32'd100,        32'd7,          32'd14},
    '{3'd7, 32'd100,        32'd7,          32'd2},
    '{3'd5, 32'd1234,       32'd0,          32'hFFFF_FFFF},
    '{3'd6, 32'd5,          32'd0,          32'd5},
    '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000},
    '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0}
  };

  initial begin
    logic [31:0] prev;
    int base;
    rst = 1'b0; start = 1'b0; flush = 1'b0; op = '0; src1 = '0; src2 = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_done", {31'b0, done}, 32'd0);
    chk("reset_result", result, 32'd0);
    chk("reset_stall", {31'b0, stall_req}, 32'd0);
    rst = 1'b1;
    idle(2);

    foreach (dir[i]) begin
      do_op(dir[i].o, dir[i].a, dir[i].b, dir[i].e);
      idle(2);
    end

    // Flush in cycle 10 of a MUL: idle next cycle, no done, result untouched.
    prev = 32'h0;  // last directed result (REM overflow case)
    base = cyc;
    op = 3'd0; src1 = 32'd3; src2 = 32'd3; start = 1'b1;
    repeat (10) @(negedge clk);
    flush = 1'b1; start = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_cycle", cyc - base, 32'd11);
    chk("flush_busy", {31'b0, busy}, 32'd0);
    chk("flush_done", {31'b0, done}, 32'd0);
    chk("flush_result", result, prev);
    idle(40);
    chk("flush_result_held", result, prev);

    // Flush together with start in IDLE must not start anything.
    op = 3'd0; src1 = 32'd5; src2 = 32'd5; start = 1'b1; flush = 1'b1;
    #1;
    chk("flush_start_stall", {31'b0, stall_req}, 32'd0);
    @(negedge clk);
    flush = 1'b0; start = 1'b0;
    chk("flush_start_busy", {31'b0, busy}, 32'd0);
    idle(3);

    // Back-to-back: second op accepted the cycle after done.
    base = cyc;
    do_op(3'd0, 32'd3, 32'd3, 32'd9);
    chk("b2b_first_done", cyc - base, 32'd33);
    do_op(3'd5, 32'd9, 32'd3, 32'd3);
    chk("b2b_second_done", cyc - base, 32'd67);
    idle(2);

    // Reset in cycle 15 aborts at once.
    op = 3'd5; src1 = 32'd100; src2 = 32'd7; start = 1'b1;
    repeat (15) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("arst_busy", {31'b0, busy}, 32'd0);
    chk("arst_done", {31'b0, done}, 32'd0);
    chk("arst_result", result, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    idle(40);
    chk("arst_result_held", result, 32'd0);

    for (int i = 0; i < 150; i++) begin
      logic [2:0]  o;
      logic [31:0] a, b;
      o = 3'($urandom_range(0, 7));
      a = pick();
      b = pick();
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
      do_op(o, a, b, model(o, a, b));
    end
    idle(5);
    chk("queue_drained", exp_res_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ex_muldiv.md
Name: ex_muldiv

Overview:
- Iterative RV32M multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register.
- Consumes the EX-stage operands (after forwarding) and an M-extension op code.
- Holds the ID/EX register, and everything upstream of it, via stall_req while it computes.
- Delivers a registered 32-bit result to the EX/MEM path on the done cycle.

Parameters:
WIDTH, 32, operand/result width; only 32 is supported; counter width is derived from it.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  EX holds a valid M-extension instruction
op  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
src1  in  32  rs1 operand (dividend / multiplicand)
src2  in  32  rs2 operand (divisor / multiplier)
flush  in  1  kill the in-flight operation (branch taken or exception)
stall_req  out  1  to hazard control; drives stop of ID/EX and upstream registers
busy  out  1  FSM not in IDLE
done  out  1  result valid, one-cycle pulse
result  out  32  registered result

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE.
  - result=0, done=0, busy=0.
  - Internal accumulator, counter and sign flags cleared.
- stall_req is combinational: start & ~done & ~flush.
  - The EX instruction is frozen until its own done cycle.
  - The pipeline advances on the done cycle.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - On start & ~flush, latch |src1|, |src2| and the sign flags per op.
    - Signed ops: MUL, MULH, DIV, REM.
    - MULHSU: src1 signed, src2 unsigned.
    - All other ops: both operands unsigned.
  - Clear the counter.
  - Normal case: go to CALC.
  - Division special cases go straight to DONE, no iterations:
    - Divisor 0: DIV/DIVU result=0xFFFFFFFF; REM/REMU result=src1.
    - DIV/REM with src1=0x80000000 and src2=0xFFFFFFFF: DIV result=0x80000000, REM result=0.
- CALC:
  - One radix-2 step per cycle for exactly 32 cycles.
  - Multiply: shift-add into a 64-bit accumulator.
  - Divide: restoring; the 32-bit remainder and quotient shift together.
  - When the counter reaches 31, go to DONE.
- Transition from CALC to DONE (end of computation):
  - Apply sign correction.
    - Product is negated if the operand signs differ.
    - Quotient is negated if the operand signs differ.
    - Remainder takes the dividend's sign.
  - Select the result half:
    - MUL: low 32 bits.
    - MULH/MULHSU/MULHU: high 32 bits.
    - DIV/DIVU: quotient.
    - REM/REMU: remainder.
  - Register the selected value into result.
- DONE: done=1 for exactly one cycle, then IDLE. busy=1 in CALC and DONE.
- Latency:
  - Normal op with start sampled in cycle 0: CALC in cycles 1–32, done=1 in cycle 33.
  - Special case: done=1 in cycle 1.
- result holds its value until the next DONE.
- If start is still high in the cycle after DONE, it is a new instruction and starts a new operation.
- Flush:
  - Has priority in every state: next state=IDLE, done is not asserted.
  - result is unchanged and the counter is cleared.
  - flush together with start in IDLE does not start an operation.
- start dropping during CALC (not flushed) is ignored; the operation completes.
- Operands and op are sampled only in IDLE. Changes to src1, src2 or op during CALC have no effect.
- Reset mid-operation aborts immediately; no done pulse follows.

Test Plan:
- MUL src1=7, src2=6 at cycle 0 → stall_req=1 in cycles 0–32; done=1, result=42 in cycle 33; stall_req=0 in cycle 33.
- MULH src1=0xFFFFFFFF (−1), src2=0xFFFFFFFF (−1) → result=0x00000000.
- MULHU with the same operands → result=0xFFFFFFFE.
- MULHSU src1=0xFFFFFFFF, src2=2 → result=0xFFFFFFFF.
- DIV src1=−7 (0xFFFFFFF9), src2=2 → result=0xFFFFFFFD (−3).
- REM with the same operands → result=0xFFFFFFFF (−1).
- DIVU src1=100, src2=7 → result=14; REMU → result=2.
- DIVU src2=0 → done=1 in cycle 1, result=0xFFFFFFFF.
- REM src1=5, src2=0 → result=5.
- DIV src1=0x80000000, src2=0xFFFFFFFF → done in cycle 1, result=0x80000000.
- MUL 3×3, flush asserted in cycle 10 → IDLE in cycle 11, no done, result keeps its previous value.
- Back-to-back: MUL 3×3 then DIVU 9/3 on the next start → done in cycle 33 (result=9), then done in cycle 67 (result=3).
- Reset mid-operation: rst=0 in cycle 15 of an operation → busy=0, done=0, result=0 immediately; no done pulse later.
